// File: rtl/sysarr_job_sched.sv
`default_nettype none
// ============================================================================
// Module : sysarr_job_sched
// Brief  : Two-requester round-robin sequencer that loads, runs and drains a
//          shared systolic-array processor through operand/result RAMs.
// Rev    : 1.0
// ============================================================================
module sysarr_job_sched #(
    parameter int AW           = 8,
    parameter int RES_WORDS    = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            g_rst,
    input  logic [1:0]      req,
    input  logic [2*AW-1:0] req_xbase,
    input  logic [2*AW-1:0] req_ybase,
    input  logic [2*AW-1:0] req_rbase,
    output logic [1:0]      done,
    output logic [1:0]      err,
    output logic            busy,
    output logic            grant,
    output logic            opm_rd,
    output logic [AW-1:0]   opm_addr,
    input  logic [31:0]     opm_rdata,
    output logic            res_we,
    output logic [AW-1:0]   res_addr,
    output logic [31:0]     res_wdata,
    output logic            sa_start,
    output logic [3:0]      sa_xaddr,
    output logic            sa_xvalid,
    output logic [31:0]     sa_xdata,
    output logic [3:0]      sa_yaddr,
    output logic            sa_yvalid,
    output logic [31:0]     sa_ydata,
    output logic [3:0]      sa_zaddr,
    input  logic            sa_flag,
    input  logic            sa_ready,
    input  logic [31:0]     sa_result
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int SW = 5;
    localparam logic [SW-1:0] c_load_last = SW'(8);
    localparam logic [SW-1:0] c_read_last = SW'(RES_WORDS);
    localparam logic [TW-1:0] c_tmo_last  = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_READ      = 3'd5,
        S_FIN       = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ptr_q, ptr_d;
    logic          grant_q, grant_d;
    logic [AW-1:0] xbase_q, xbase_d;
    logic [AW-1:0] ybase_q, ybase_d;
    logic [AW-1:0] rbase_q, rbase_d;
    logic          w_pick;
    logic [SW-1:0] w_idx;

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            tmo_q   <= '0;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            xbase_q <= '0;
            ybase_q <= '0;
            rbase_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            xbase_q <= xbase_d;
            ybase_q <= ybase_d;
            rbase_q <= rbase_d;
        end
    end

    assign grant = grant_q;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tmo_d     = tmo_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        xbase_d   = xbase_q;
        ybase_d   = ybase_q;
        rbase_d   = rbase_q;
        w_pick    = (&req) ? ptr_q : req[1];
        // Data returned this cycle belongs to the request issued one step earlier.
        w_idx     = step_q - SW'(1);
        busy      = 1'b0;
        done      = 2'b00;
        err       = 2'b00;
        opm_rd    = 1'b0;
        opm_addr  = '0;
        res_we    = 1'b0;
        res_addr  = '0;
        res_wdata = '0;
        sa_start  = 1'b0;
        sa_xaddr  = '0;
        sa_xvalid = 1'b0;
        sa_xdata  = '0;
        sa_yaddr  = '0;
        sa_yvalid = 1'b0;
        sa_ydata  = '0;
        sa_zaddr  = '0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = w_pick;
                    xbase_d = w_pick ? req_xbase[2*AW-1:AW] : req_xbase[AW-1:0];
                    ybase_d = w_pick ? req_ybase[2*AW-1:AW] : req_ybase[AW-1:0];
                    rbase_d = w_pick ? req_rbase[2*AW-1:AW] : req_rbase[AW-1:0];
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                // Steps 0..3 fetch x words, 4..7 fetch y words; step 8 only drains.
                if (!step_q[3]) begin
                    opm_rd   = 1'b1;
                    opm_addr = (step_q[2] ? ybase_q : xbase_q) + AW'(step_q[1:0]);
                end
                if (step_q != '0 && !w_idx[2]) begin
                    sa_xvalid = 1'b1;
                    sa_xaddr  = {2'b00, w_idx[1:0]};
                    sa_xdata  = opm_rdata;
                end
                if (step_q != '0 && w_idx[2]) begin
                    sa_yvalid = 1'b1;
                    sa_yaddr  = {2'b00, w_idx[1:0]};
                    sa_ydata  = opm_rdata;
                end
                if (step_q == c_load_last) begin
                    step_d  = '0;
                    state_d = S_START;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_START: begin
                busy     = 1'b1;
                sa_start = 1'b1;
                tmo_d    = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                busy = 1'b1;
                if (sa_flag) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_q == c_tmo_last) begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_WAIT_DONE: begin
                busy = 1'b1;
                if (!sa_flag && sa_ready) begin
                    step_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (step_q < c_read_last) begin
                    sa_zaddr = step_q[3:0];
                end
                if (step_q != '0) begin
                    res_we    = 1'b1;
                    res_addr  = rbase_q + AW'(w_idx);
                    res_wdata = sa_result;
                end
                if (step_q == c_read_last) begin
                    state_d = S_FIN;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_FIN: begin
                done    = grant_q ? 2'b10 : 2'b01;
                ptr_d   = ~grant_q;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                err     = grant_q ? 2'b10 : 2'b01;
                ptr_d   = ~grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
